// File: rtl/count_pwm_generator.sv
// count_pwm_generator: PWM aligned to an upstream free-running WIDTH-bit counter.
// Duty values are buffered in a one-entry shadow register and applied only at a
// period boundary (count wrapping from all-ones to zero). Count continuity is
// monitored and a sticky flag records any unexpected step.
module count_pwm_generator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             seq_err
);

    localparam logic [WIDTH:0]   FULL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   active_duty, pending_duty, eff_duty, duty_clamped;
    logic             pending_valid, prev_valid;
    logic [WIDTH-1:0] prev_count, expect_count;
    logic             ps, hold, step_err, accept;
    logic             apply, pwm_nxt, tick_nxt, err_set;

    assign duty_clamped = (duty_in > FULL) ? FULL : duty_in;
    assign expect_count = prev_count + 1'b1;

    // Period start: a genuine wrap from the last count back to zero.
    assign ps       = prev_valid && (count == '0) && (prev_count == LAST);
    // Counter parked at zero (upstream held in reset) is not an error.
    assign hold     = (count == '0) && (prev_count == '0);
    assign step_err = prev_valid && (count != expect_count) && !ps && !hold;

    assign duty_ready = rst && !pending_valid;
    assign accept     = duty_valid && duty_ready;

    // A pending duty takes effect on the very cycle of the boundary it is applied at.
    assign eff_duty = (ps && pending_valid) ? pending_duty : active_duty;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and next-output decode; enable=0 wins over all other events.
    always_comb begin
        state_nxt = state;
        pwm_nxt   = 1'b0;
        tick_nxt  = 1'b0;
        err_set   = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = SYNC;
            end
            SYNC: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (ps) begin
                    state_nxt = RUN;
                    apply     = 1'b1;
                    tick_nxt  = 1'b1;
                    pwm_nxt   = ({1'b0, count} < eff_duty);
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (step_err) begin
                    state_nxt = SYNC;
                    err_set   = 1'b1;
                end else if (hold) begin
                    state_nxt = SYNC;
                end else begin
                    pwm_nxt = ({1'b0, count} < eff_duty);
                    if (ps) begin
                        apply    = 1'b1;
                        tick_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: outputs, shadow buffer, count history, sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_out       <= 1'b0;
            period_tick   <= 1'b0;
            seq_err       <= 1'b0;
            active_duty   <= '0;
            pending_duty  <= '0;
            pending_valid <= 1'b0;
            prev_count    <= '0;
            prev_valid    <= 1'b0;
        end else begin
            pwm_out     <= pwm_nxt;
            period_tick <= tick_nxt;
            prev_count  <= count;
            prev_valid  <= 1'b1;
            if (err_set) seq_err <= 1'b1;
            // Apply and accept are exclusive: accept needs an empty buffer.
            if (apply && pending_valid) begin
                active_duty   <= pending_duty;
                pending_valid <= 1'b0;
            end else if (accept) begin
                pending_duty  <= duty_clamped;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_pwm_generator.sv
// Directed bench for count_pwm_generator: the bench plays the upstream counter,
// pushes the expected {pwm, tick, err} for each driven count into a scoreboard
// queue and pops/compares it after the following clock edge.
module tb_count_pwm_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count = '0;
    logic       enable = 1'b0;
    logic [4:0] duty_in = '0;
    logic       duty_valid = 1'b0;
    logic       duty_ready, pwm_out, period_tick, seq_err;

    int         total = 0;
    int         bad = 0;
    logic [2:0] sb[$];

    count_pwm_generator #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .count(count), .enable(enable),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm_out(pwm_out), .period_tick(period_tick), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Drive one count value, expect the given outputs after the next edge.
    task automatic cyc(input logic [3:0] c, input logic ep, input logic et, input logic ee);
        logic       acc;
        logic [2:0] e;
        count = c;
        sb.push_back({ep, et, ee});
        acc = duty_valid && duty_ready;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("pwm c=%0d", c),  pwm_out,     e[2]);
        chk($sformatf("tick c=%0d", c), period_tick, e[1]);
        chk($sformatf("err c=%0d", c),  seq_err,     e[0]);
        if (acc) duty_valid = 1'b0;
    endtask

    // One full counter period with effective duty k; optionally offer a duty
    // at count inj_at (held until the DUT accepts it).
    task automatic period(input int k, input logic tick, input int inj_at,
                          input logic [4:0] inj_val, input logic err);
        for (int c = 0; c < 16; c++) begin
            if (c == inj_at) begin
                duty_valid = 1'b1;
                duty_in    = inj_val;
            end
            cyc(4'(c), (c < k), (tick && c == 0), err);
        end
    endtask

    initial begin
        enable = 1'b1;
        // 1: reset, then free-running counter; no pwm until first wrap
        repeat (3) cyc(4'd0, 1'b0, 1'b0, 1'b0);
        chk("ready_in_reset", duty_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("ready_after_rel", duty_ready, 1'b1);
        period(0, 1'b0, -1, 5'd0, 1'b0);
        // 2: first RUN period with duty 0, duty 5 offered mid-period
        period(0, 1'b1, 3, 5'd5, 1'b0);
        chk("ready_full", duty_ready, 1'b0);
        period(5, 1'b1, -1, 5'd0, 1'b0);
        chk("ready_after_ps", duty_ready, 1'b1);
        period(5, 1'b1, -1, 5'd0, 1'b0);
        // 3: duty 0, 16, 31 (clamped to 16)
        period(5, 1'b1, 2, 5'd0, 1'b0);
        period(0, 1'b1, 4, 5'd16, 1'b0);
        period(16, 1'b1, 4, 5'd31, 1'b0);
        period(16, 1'b1, -1, 5'd0, 1'b0);
        // 5: counter wraps then stays at 0 -> SYNC without error
        cyc(4'd0, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(4'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 16; c++) cyc(4'(c), 1'b0, 1'b0, 1'b0);
        period(16, 1'b1, -1, 5'd0, 1'b0);
        // 4: jump 6 -> 9 in RUN, sticky error, resync at next wrap
        cyc(4'd0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 6; c++) cyc(4'(c), 1'b1, 1'b0, 1'b0);
        cyc(4'd9, 1'b0, 1'b0, 1'b1);
        for (int c = 10; c < 16; c++) cyc(4'(c), 1'b0, 1'b0, 1'b1);
        period(16, 1'b1, -1, 5'd0, 1'b1);
        // 6: pending 7, offer 3 at the boundary -> 7 now, 3 next period
        period(16, 1'b1, 2, 5'd7, 1'b1);
        chk("ready_pend7", duty_ready, 1'b0);
        period(7, 1'b1, 0, 5'd3, 1'b1);
        chk("ready_pend3", duty_ready, 1'b0);
        period(3, 1'b1, -1, 5'd0, 1'b1);
        // mid-period reset with a pending duty of 9
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                duty_valid = 1'b1;
                duty_in    = 5'd9;
            end
            cyc(4'(c), (c < 3), (c == 0), 1'b1);
        end
        chk("ready_pend9", duty_ready, 1'b0);
        rst = 1'b0;
        cyc(4'd4, 1'b0, 1'b0, 1'b0);
        chk("ready_mid_reset", duty_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("ready_discarded", duty_ready, 1'b1);
        period(0, 1'b0, -1, 5'd0, 1'b0);
        period(0, 1'b1, -1, 5'd0, 1'b0);
        chk("sb_empty", (sb.size() == 0), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
